bus_interface_register_fifo: RTL

- Parametrised successor to the 8-bit bus interface register chip model used on the EDiC data bus.
- Keeps the chip's control set: active-low clear, active-low clock enable, and multiple active-low output enables that must all be asserted to drive.
- Generalises data width and output-enable count.
- Replaces the single latch stage with a DEPTH-entry elastic buffer and valid/ready handshakes, so bus producers and consumers can decouple by several cycles.

---
 rtl/bir_pkg.sv | 22 ++
 rtl/bus_interface_register_fifo_storage.sv | 38 +++
 rtl/bus_interface_register_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/bir_pkg.sv
// Shared definitions for the bus interface register FIFO: parameter limits,
// the output-enable reduction and the occupancy counter width helper.
package bir_pkg;

    localparam int unsigned MIN_WIDTH  = 1;
    localparam int unsigned MAX_WIDTH  = 64;
    localparam int unsigned MIN_DEPTH  = 2;
    localparam int unsigned MAX_DEPTH  = 16;
    localparam int unsigned MIN_NUM_OE = 1;
    localparam int unsigned MAX_NUM_OE = 8;

    // True only when every enable bit is asserted (low); callers zero-extend.
    function automatic logic all_low(input logic [MAX_NUM_OE-1:0] v);
        return ~|v;
    endfunction

    // Count must represent 0..DEPTH inclusive, hence one bit beyond the pointer.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_interface_register_fifo_storage.sv
// WIDTH x DEPTH register array with one write port and an asynchronous read
// port; cleared to zero by the synchronous reset.
module bir_storage
    import bir_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_interface_register_fifo.sv
// Elastic bus interface register: DEPTH-entry FIFO with valid/ready handshakes,
// active-low clear, active-low clock enable and multi-bit active-low output enable.
module bus_interface_register_fifo
    import bir_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_OE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_n,
    input  logic                   clken_n,
    input  logic [WIDTH-1:0]       d,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_OE-1:0]      oe_n,
    output logic [WIDTH-1:0]       q,
    output logic                   q_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("WIDTH out of range");
    end
    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in range");
    end
    if (NUM_OE < MIN_NUM_OE || NUM_OE > MAX_NUM_OE) begin : g_bad_num_oe
        $error("NUM_OE out of range");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [MAX_NUM_OE-1:0] oe_ext;
    logic [WIDTH-1:0]      rdata;
    logic                  full;
    logic                  push;
    logic                  pop;

    always_comb begin
        oe_ext             = '0;
        oe_ext[NUM_OE-1:0] = oe_n;
    end

    assign q_en      = all_low(oe_ext);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = !full && !clken_n && clr_n && !rst;
    assign out_valid = (count_q != '0) && q_en && !clken_n && clr_n;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign q         = q_en ? rdata : '0;
    assign count     = count_q;

    // Handshake terms already carry clken_n/clr_n gating; clear only needs resets.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!clr_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    bir_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

endmodule
